// File: rtl/aes_round_ops.sv
// AES-128 encryption round transforms (AddRoundKey, ShiftRows, MixColumns),
// each a registered unit with its own enable/done handshake.
module aes_round_ops (
  input  logic         clk,
  input  logic         reset,
  input  logic         ark_en,
  input  logic [127:0] ark_key,
  input  logic [127:0] ark_state,
  output logic [127:0] ark_out,
  output logic         ark_done,
  input  logic         sr_en,
  input  logic [127:0] sr_data,
  output logic [127:0] sr_out,
  output logic         sr_done,
  input  logic         mc_en,
  input  logic [127:0] mc_state,
  output logic [127:0] mc_out,
  output logic         mc_done
);

  logic [127:0] ark_out_q, ark_out_d;
  logic [127:0] sr_out_q,  sr_out_d;
  logic [127:0] mc_out_q,  mc_out_d;
  logic         ark_done_q, ark_done_d;
  logic         sr_done_q,  sr_done_d;
  logic         mc_done_q,  mc_done_d;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
    b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  // Byte k sits at [127-8k -: 8]; row = k%4, column = k/4.
  function automatic logic [127:0] shift_rows(input logic [127:0] din);
    logic [127:0] dout;
    dout = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        dout[127 - 8*(4*c + r) -: 8] = din[127 - 8*(4*((c + r) % 4) + r) -: 8];
      end
    end
    return dout;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] din);
    logic [127:0] dout;
    dout = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      dout[127 - 32*c -: 32] = mix_column(din[127 - 32*c -: 32]);
    end
    return dout;
  endfunction

  always_comb begin
    ark_out_d  = ark_out_q;
    sr_out_d   = sr_out_q;
    mc_out_d   = mc_out_q;
    ark_done_d = ark_en;
    sr_done_d  = sr_en;
    mc_done_d  = mc_en;
    if (ark_en) ark_out_d = ark_state ^ ark_key;
    if (sr_en)  sr_out_d  = shift_rows(sr_data);
    if (mc_en)  mc_out_d  = mix_columns(mc_state);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ark_out_q  <= '0;
      sr_out_q   <= '0;
      mc_out_q   <= '0;
      ark_done_q <= 1'b0;
      sr_done_q  <= 1'b0;
      mc_done_q  <= 1'b0;
    end else begin
      ark_out_q  <= ark_out_d;
      sr_out_q   <= sr_out_d;
      mc_out_q   <= mc_out_d;
      ark_done_q <= ark_done_d;
      sr_done_q  <= sr_done_d;
      mc_done_q  <= mc_done_d;
    end
  end

  assign ark_out  = ark_out_q;
  assign sr_out   = sr_out_q;
  assign mc_out   = mc_out_q;
  assign ark_done = ark_done_q;
  assign sr_done  = sr_done_q;
  assign mc_done  = mc_done_q;

endmodule

// File: tb/tb_aes_round_ops.sv
// Directed bench for aes_round_ops using FIPS-197 round vectors.
module tb_aes_round_ops;

  logic         clk = 1'b0;
  logic         reset;
  logic         ark_en, sr_en, mc_en;
  logic [127:0] ark_key, ark_state, sr_data, mc_state;
  logic [127:0] ark_out, sr_out, mc_out;
  logic         ark_done, sr_done, mc_done;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  localparam logic [127:0] ARK_S   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] ARK_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ARK_R   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] SR_I    = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] SR_R    = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] MC_I    = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] MC_R    = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] MC_I2   = 128'hdb135345f20a225c01010101c6c6c6c6;
  localparam logic [127:0] MC_R2   = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
  localparam logic [127:0] MC_I3   = 128'hd4d4d4d52d26314cdb135345db135345;
  localparam logic [127:0] MC_R3   = 128'hd5d5d7d64d7ebdf88e4da1bc8e4da1bc;

  aes_round_ops dut (
    .clk       (clk),
    .reset     (reset),
    .ark_en    (ark_en),
    .ark_key   (ark_key),
    .ark_state (ark_state),
    .ark_out   (ark_out),
    .ark_done  (ark_done),
    .sr_en     (sr_en),
    .sr_data   (sr_data),
    .sr_out    (sr_out),
    .sr_done   (sr_done),
    .mc_en     (mc_en),
    .mc_state  (mc_state),
    .mc_out    (mc_out),
    .mc_done   (mc_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset     = 1'b0;
    ark_en    = 1'b1;
    sr_en     = 1'b1;
    mc_en     = 1'b1;
    ark_key   = {$urandom, $urandom, $urandom, $urandom};
    ark_state = {$urandom, $urandom, $urandom, $urandom};
    sr_data   = {$urandom, $urandom, $urandom, $urandom};
    mc_state  = {$urandom, $urandom, $urandom, $urandom};
    tick();
    tick();
    chk("rst_ark_out", ark_out, '0);
    chk("rst_sr_out",  sr_out,  '0);
    chk("rst_mc_out",  mc_out,  '0);
    chk("rst_dones", {125'b0, ark_done, sr_done, mc_done}, '0);

    // Release with only ARK enabled
    sr_en     = 1'b0;
    mc_en     = 1'b0;
    ark_state = ARK_S;
    ark_key   = ARK_K;
    reset     = 1'b1;
    chk("pre_edge_ark_done", {127'b0, ark_done}, '0);
    tick();
    chk("first_ark_done", {127'b0, ark_done}, 128'd1);
    chk("ark_vec", ark_out, ARK_R);
    chk("sr_idle_done", {127'b0, sr_done}, '0);

    // Handshake: en high three edges, then low
    tick();
    chk("ark_done_c2", {127'b0, ark_done}, 128'd1);
    tick();
    chk("ark_done_c3", {127'b0, ark_done}, 128'd1);
    ark_en    = 1'b0;
    ark_state = '1;
    tick();
    chk("ark_done_drop", {127'b0, ark_done}, '0);
    chk("ark_hold", ark_out, ARK_R);
    tick();
    chk("ark_done_low2", {127'b0, ark_done}, '0);
    chk("ark_hold2", ark_out, ARK_R);
    ark_en = 1'b1;
    chk("ark_reraise_gap", {127'b0, ark_done}, '0);
    tick();
    chk("ark_reraise_done", {127'b0, ark_done}, 128'd1);
    chk("ark_reraise_out", ark_out, ~ARK_K);

    // Tracking input changes while en stays high
    ark_state = ARK_K;
    tick();
    chk("ark_track_zero", ark_out, '0);
    ark_en = 1'b0;

    // ShiftRows and MixColumns individually
    sr_en   = 1'b1;
    sr_data = SR_I;
    tick();
    chk("sr_vec", sr_out, SR_R);
    chk("sr_done", {127'b0, sr_done}, 128'd1);
    sr_en    = 1'b0;
    mc_en    = 1'b1;
    mc_state = MC_I;
    tick();
    chk("mc_vec", mc_out, MC_R);
    chk("mc_done", {127'b0, mc_done}, 128'd1);
    chk("sr_done_off", {127'b0, sr_done}, '0);
    mc_state = MC_I2;
    tick();
    chk("mc_vec2", mc_out, MC_R2);
    mc_state = MC_I3;
    tick();
    chk("mc_vec3", mc_out, MC_R3);
    mc_en = 1'b0;
    tick();

    // All three units together
    ark_en = 1'b1; ark_state = ARK_S; ark_key = ARK_K;
    sr_en  = 1'b1; sr_data = SR_I;
    mc_en  = 1'b1; mc_state = MC_I;
    tick();
    chk("all_ark", ark_out, ARK_R);
    chk("all_sr",  sr_out,  SR_R);
    chk("all_mc",  mc_out,  MC_R);
    chk("all_dones", {125'b0, ark_done, sr_done, mc_done}, 128'd7);

    // Asynchronous reset mid-run
    reset = 1'b0;
    #1;
    chk("mid_rst_outs", ark_out | sr_out | mc_out, '0);
    chk("mid_rst_dones", {125'b0, ark_done, sr_done, mc_done}, '0);
    tick();
    chk("mid_rst_held", ark_out | sr_out | mc_out, '0);
    ark_en = 1'b0; sr_en = 1'b0; mc_en = 1'b0;
    reset  = 1'b1;
    tick();
    chk("post_rst_no_done", {125'b0, ark_done, sr_done, mc_done}, '0);
    chk("post_rst_outs", ark_out | sr_out | mc_out, '0);
    sr_en = 1'b1;
    tick();
    chk("post_rst_sr", sr_out, SR_R);
    chk("post_rst_dones", {125'b0, ark_done, sr_done, mc_done}, 128'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
